led_pattern_driver: RTL and testbench
=====================================

Name: led_pattern_driver

Overview:
Output-side counterpart to the debounced button inputs: consumes single-cycle command strobes from the game logic and drives three indicator LEDs with steady, blinking or counted-flash patterns. It sits between the control FSM and the board LED pins. It replaces ad-hoc toggle-on-edge LED logic with one clocked block that has an explicit accept handshake.

Parameters:
TICK_DIV, 2500000, clk cycles per pattern tick (50 ms at 50 MHz); minimum 2
BLINK_TICKS, 5, ticks per half-period of BLINK and FLASH patterns; minimum 1

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  command strobe; sampled every clk
cmd_ch  in  2  target channel 0..2; value 3 is invalid
cmd_mode  in  2  0=OFF, 1=ON, 2=BLINK, 3=FLASH
cmd_count  in  4  number of flashes for FLASH mode
cmd_ready  out  1  combinational; 0 while channel cmd_ch is in FLASH, else 1
led  out  3  registered LED drive, bit i = channel i
flash_done  out  3  registered one-cycle pulse when channel i finishes a FLASH

Behaviour:
- Reset (reset=0, asynchronous): prescaler=0, all channels OFF, led=3'b000, flash_done=3'b000, phase and flash counters cleared. Reset mid-pattern aborts it immediately; no flash_done is emitted.
- Prescaler: free-running counter 0..TICK_DIV-1 shared by all channels. tick=1 for exactly one clk when counter==TICK_DIV-1, then wraps to 0. The prescaler is never restarted by commands, so the first half-period after acceptance is shortened by 0..TICK_DIV-1 cycles.
- Accept: cmd_valid && cmd_ready in the same clk. Commands with cmd_ch=3 are accepted (cmd_ready=1) and discarded. A command to a channel in FLASH is not accepted; the sender holds cmd_valid until cmd_ready=1.
- Per-channel state machine: OFF, ON, BLINK, FLASH. A phase counter counts ticks, and a flash counter holds the remaining flashes.
- Latency: led[i] takes its new value on the clk edge that accepts the command, visible in the following cycle.
- OFF: led=0. ON: led=1.
- BLINK: on accept, led=1 and phase=0. Each tick increments phase. When phase reaches BLINK_TICKS-1 and a tick occurs, led toggles and phase=0. The channel stays in BLINK until a new command arrives.
- FLASH with cmd_count=N>0: on accept, led=1, phase=0, remaining=N. Half-periods are timed as in BLINK. At the end of each off-half, remaining decrements. At the end of the Nth off-half, the channel goes to OFF and flash_done[i]=1 for that one cycle. cmd_ready for channel i returns to 1 in the next cycle.
- FLASH with cmd_count=0: treated as OFF, with no flash_done pulse.
- Any accepted command to a channel in OFF/ON/BLINK takes effect immediately; BLINK phase restarts from led=1.
- Channels are independent. Commands arrive one per cycle, so at most one channel changes by command per clk. Tick-driven updates on the other channels occur in the same cycle.
- Tick and accept on the same channel in the same cycle: the command wins and the tick is ignored for that channel.

Test Plan:
- TICK_DIV=4, BLINK_TICKS=2. Reset low for 3 cycles -> led=000, flash_done=000, cmd_ready=1. Release reset and send ch1 ON -> led=010 in the next cycle and held indefinitely.
- Send ch0 BLINK -> led[0]=1, then toggles every 8 clk after the first (shortened) half-period. Send ch0 OFF mid-blink -> led[0]=0 in the next cycle and stays 0.
- Send ch2 FLASH, count=3 -> exactly 3 high pulses on led[2], each 8 clk except the first. flash_done[2]=1 for one cycle coincident with the final off transition to OFF. cmd_ready for ch2 is 0 throughout.
- During ch2 FLASH, hold cmd_valid with ch2 ON -> not accepted until flash_done[2]. ON then applies in the following accept cycle. A ch0 command during the flash is accepted at once.
- Send ch2 FLASH, count=0 -> led[2]=0 and no flash_done. Send cmd_ch=3 ON -> cmd_ready=1 and led unchanged.
- Assert reset during ch1 FLASH (count=5, second pulse) -> led=000 immediately without waiting for a clk edge, and no flash_done. After release, ch1 accepts a command on the first cycle.

Source files
------------

// File: rtl/led_pattern_driver_if.sv
// Command channel from the game control logic to the LED pattern driver.
// The sender drives a one-cycle strobe with channel, mode and flash count;
// the driver answers with a combinational ready that is low only while the
// addressed channel is busy with a counted flash.
interface led_pattern_driver_if;
    logic       cmd_valid;
    logic [1:0] cmd_ch;
    logic [1:0] cmd_mode;
    logic [3:0] cmd_count;
    logic       cmd_ready;

    modport master (
        output cmd_valid,
        output cmd_ch,
        output cmd_mode,
        output cmd_count,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_ch,
        input  cmd_mode,
        input  cmd_count,
        output cmd_ready
    );
endinterface

// File: rtl/led_pattern_driver.sv
// Three-channel LED pattern driver: OFF, ON, BLINK and counted FLASH
// patterns timed by one shared free-running tick prescaler. Commands take
// effect on the accepting edge; a channel in FLASH refuses new commands
// until its last flash has finished and flash_done has pulsed.
module led_pattern_driver #(
    parameter int unsigned TICK_DIV    = 2500000,
    parameter int unsigned BLINK_TICKS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    led_pattern_driver_if.slave   cmd,
    output logic [2:0]            led,
    output logic [2:0]            flash_done
);

    localparam int unsigned PRESC_W = $clog2(TICK_DIV);
    localparam int unsigned PHASE_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(BLINK_TICKS - 1);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_FLASH = 2'd3
    } mode_t;

    logic [PRESC_W-1:0] presc_q;
    logic               tick;
    logic               accept;

    mode_t              state_q  [3];
    mode_t              state_d  [3];
    logic [PHASE_W-1:0] phase_q  [3];
    logic [PHASE_W-1:0] phase_d  [3];
    logic [3:0]         remain_q [3];
    logic [3:0]         remain_d [3];
    logic [2:0]         led_d;
    logic [2:0]         done_d;

    assign tick   = (presc_q == PRESC_LAST);
    assign accept = cmd.cmd_valid && cmd.cmd_ready;

    // Shared prescaler, never restarted by commands, wraps after the tick cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            presc_q <= '0;
        else if (tick)
            presc_q <= '0;
        else
            presc_q <= presc_q + PRESC_W'(1);
    end

    // Ready is withheld only when the addressed channel is mid-flash; channel 3 is a sink
    always_comb begin
        cmd.cmd_ready = 1'b1;
        case (cmd.cmd_ch)
            2'd0:    cmd.cmd_ready = (state_q[0] != MODE_FLASH);
            2'd1:    cmd.cmd_ready = (state_q[1] != MODE_FLASH);
            2'd2:    cmd.cmd_ready = (state_q[2] != MODE_FLASH);
            default: cmd.cmd_ready = 1'b1;
        endcase
    end

    // Per-channel next state: an accepted command wins over a tick on the same channel
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        remain_d = remain_q;
        led_d    = led;
        done_d   = '0;
        for (int i = 0; i < 3; i++) begin
            if (accept && (cmd.cmd_ch == 2'(i))) begin
                phase_d[i]  = '0;
                remain_d[i] = '0;
                case (cmd.cmd_mode)
                    2'd0: begin
                        state_d[i] = MODE_OFF;
                        led_d[i]   = 1'b0;
                    end
                    2'd1: begin
                        state_d[i] = MODE_ON;
                        led_d[i]   = 1'b1;
                    end
                    2'd2: begin
                        state_d[i] = MODE_BLINK;
                        led_d[i]   = 1'b1;
                    end
                    default: begin
                        if (cmd.cmd_count == 4'd0) begin
                            state_d[i] = MODE_OFF;
                            led_d[i]   = 1'b0;
                        end else begin
                            state_d[i]  = MODE_FLASH;
                            led_d[i]    = 1'b1;
                            remain_d[i] = cmd.cmd_count;
                        end
                    end
                endcase
            end else if (tick && ((state_q[i] == MODE_BLINK) || (state_q[i] == MODE_FLASH))) begin
                if (phase_q[i] != PHASE_LAST) begin
                    phase_d[i] = phase_q[i] + PHASE_W'(1);
                end else begin
                    phase_d[i] = '0;
                    if ((state_q[i] == MODE_FLASH) && !led[i]) begin
                        if (remain_q[i] <= 4'd1) begin
                            state_d[i]  = MODE_OFF;
                            remain_d[i] = '0;
                            done_d[i]   = 1'b1;
                        end else begin
                            remain_d[i] = remain_q[i] - 4'd1;
                            led_d[i]    = 1'b1;
                        end
                    end else begin
                        led_d[i] = ~led[i];
                    end
                end
            end
        end
    end

    // Channel state, counters and registered LED / done outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                state_q[i]  <= MODE_OFF;
                phase_q[i]  <= '0;
                remain_q[i] <= '0;
            end
            led        <= '0;
            flash_done <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                state_q[i]  <= state_d[i];
                phase_q[i]  <= phase_d[i];
                remain_q[i] <= remain_d[i];
            end
            led        <= led_d;
            flash_done <= done_d;
        end
    end

endmodule

// File: tb/tb_led_pattern_driver.sv
// Directed bench for led_pattern_driver with TICK_DIV=4, BLINK_TICKS=2
// (half-period 8 clk). Edge Pk is the k-th rising edge after reset release;
// the prescaler ticks on every edge with k divisible by 4.
module tb_led_pattern_driver;

    logic       clk;
    logic       reset;
    logic [2:0] led;
    logic [2:0] flash_done;
    int         total;
    int         bad;

    led_pattern_driver_if cmd_bus ();

    led_pattern_driver #(
        .TICK_DIV    (4),
        .BLINK_TICKS (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd        (cmd_bus.slave),
        .led        (led),
        .flash_done (flash_done)
    );

    typedef struct {
        logic       valid;
        logic [1:0] ch;
        logic [1:0] mode;
        logic [3:0] count;
        logic       exp_ready;
        logic [2:0] exp_led;
        logic [2:0] exp_done;
    } vec_t;

    vec_t vecs [24];

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run can never hang
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mkVec(logic v, logic [1:0] c, logic [1:0] m, logic [3:0] n,
                                   logic r, logic [2:0] l, logic [2:0] d);
        vec_t t;
        t.valid     = v;
        t.ch        = c;
        t.mode      = m;
        t.count     = n;
        t.exp_ready = r;
        t.exp_led   = l;
        t.exp_done  = d;
        return t;
    endfunction

    task automatic applyStimulus(input logic v, input logic [1:0] c, input logic [1:0] m,
                                 input logic [3:0] n);
        cmd_bus.cmd_valid = v;
        cmd_bus.cmd_ch    = c;
        cmd_bus.cmd_mode  = m;
        cmd_bus.cmd_count = n;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [2:0] actual,
                               input logic [2:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic       l0;
        logic       l1;
        logic       l2;
        logic       rdy;

        total = 0;
        bad   = 0;
        reset = 1'b0;
        applyStimulus(1'b0, 2'd0, 2'd0, 4'd0);

        // Reset held across three rising edges
        repeat (3) @(negedge clk);
        checkOutput("reset led", led, 3'b000);
        checkOutput("reset done", flash_done, 3'b000);
        checkOutput("reset ready", {2'b00, cmd_bus.cmd_ready}, 3'b001);
        reset = 1'b1;

        // Table: row j is driven before edge P(j+1)
        for (int j = 0; j < 24; j++)
            vecs[j] = mkVec(1'b0, 2'd0, 2'd0, 4'd0, 1'b1, 3'b010, 3'b000);
        vecs[0]  = mkVec(1'b1, 2'd1, 2'd1, 4'd0, 1'b1, 3'b010, 3'b000);
        vecs[1]  = mkVec(1'b1, 2'd0, 2'd2, 4'd0, 1'b1, 3'b011, 3'b000);
        for (int j = 2; j <= 6; j++)
            vecs[j] = mkVec(1'b0, 2'd0, 2'd0, 4'd0, 1'b1, 3'b011, 3'b000);
        vecs[15] = mkVec(1'b0, 2'd0, 2'd0, 4'd0, 1'b1, 3'b011, 3'b000);
        vecs[16] = mkVec(1'b1, 2'd0, 2'd0, 4'd0, 1'b1, 3'b010, 3'b000);
        vecs[20] = mkVec(1'b1, 2'd3, 2'd1, 4'd0, 1'b1, 3'b010, 3'b000);
        vecs[21] = mkVec(1'b1, 2'd2, 2'd3, 4'd0, 1'b1, 3'b010, 3'b000);

        for (int j = 0; j < 24; j++) begin
            applyStimulus(vecs[j].valid, vecs[j].ch, vecs[j].mode, vecs[j].count);
            checkOutput($sformatf("vec%0d ready", j), {2'b00, cmd_bus.cmd_ready},
                        {2'b00, vecs[j].exp_ready});
            stepCycle();
            checkOutput($sformatf("vec%0d led", j), led, vecs[j].exp_led);
            checkOutput($sformatf("vec%0d done", j), flash_done, vecs[j].exp_done);
        end

        // ch2 FLASH x3 at P25, ch0 ON at P27, ch2 ON held from P28 until accepted at P73
        for (int k = 25; k <= 74; k++) begin
            if (k == 25)
                applyStimulus(1'b1, 2'd2, 2'd3, 4'd3);
            else if (k == 27)
                applyStimulus(1'b1, 2'd0, 2'd1, 4'd0);
            else if ((k >= 28) && (k <= 73))
                applyStimulus(1'b1, 2'd2, 2'd1, 4'd0);
            else
                applyStimulus(1'b0, 2'd0, 2'd0, 4'd0);
            rdy = !((k >= 28) && (k <= 72));
            checkOutput($sformatf("flash P%0d ready", k), {2'b00, cmd_bus.cmd_ready},
                        {2'b00, rdy});
            stepCycle();
            l0 = (k >= 27);
            l2 = ((k >= 25) && (k <= 31)) || ((k >= 40) && (k <= 47)) ||
                 ((k >= 56) && (k <= 63)) || (k >= 73);
            checkOutput($sformatf("flash P%0d led", k), led, {l2, 1'b1, l0});
            checkOutput($sformatf("flash P%0d done", k), flash_done,
                        (k == 72) ? 3'b100 : 3'b000);
        end

        // ch1 FLASH x5 at P75, refused ch1 OFF at P77, reset during second pulse
        for (int k = 75; k <= 89; k++) begin
            if (k == 75)
                applyStimulus(1'b1, 2'd1, 2'd3, 4'd5);
            else if (k == 77)
                applyStimulus(1'b1, 2'd1, 2'd0, 4'd0);
            else
                applyStimulus(1'b0, 2'd0, 2'd0, 4'd0);
            rdy = (k != 77);
            checkOutput($sformatf("rst P%0d ready", k), {2'b00, cmd_bus.cmd_ready},
                        {2'b00, rdy});
            stepCycle();
            l1 = (k <= 79) || (k >= 88);
            checkOutput($sformatf("rst P%0d led", k), led, {1'b1, l1, 1'b1});
            checkOutput($sformatf("rst P%0d done", k), flash_done, 3'b000);
        end

        // Asynchronous reset between clock edges
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async reset led", led, 3'b000);
        checkOutput("async reset done", flash_done, 3'b000);
        for (int k = 0; k < 2; k++) begin
            stepCycle();
            checkOutput($sformatf("held reset led %0d", k), led, 3'b000);
            checkOutput($sformatf("held reset done %0d", k), flash_done, 3'b000);
        end
        reset = 1'b1;

        // First cycle after release accepts a ch1 command
        applyStimulus(1'b1, 2'd1, 2'd1, 4'd0);
        checkOutput("post reset ready", {2'b00, cmd_bus.cmd_ready}, 3'b001);
        stepCycle();
        checkOutput("post reset led", led, 3'b010);
        checkOutput("post reset done", flash_done, 3'b000);
        applyStimulus(1'b0, 2'd0, 2'd0, 4'd0);
        stepCycle();
        checkOutput("post reset hold led", led, 3'b010);
        checkOutput("post reset hold done", flash_done, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
